// File: rtl/cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_ctrl
// Purpose  : Frame-synchronous scheduler for the pointer overlay. Arbitrates
//            position updates from the mouse stream and the game logic, clamps
//            them to the visible area and commits them only on vblank entry,
//            so the overlay never tears mid-frame.
// Ports    : clk, rst             pixel clock, synchronous active-high reset
//            vblnk                vertical blank from the VGA timing chain
//            mouse_valid/x/y/left mouse sample strobe, position, button level
//            set_req/set_x/set_y  game position request (held until set_ack)
//            set_ack              one-cycle accept pulse
//            x, y                 committed cursor position
//            cursor_vis           overlay enable
//            frame_click          one-cycle pulse at commit if left was pressed
// Config   : CURSOR_AUTOHIDE_EN   when defined, hides the cursor after
//                                 IDLE_FRAMES vblanks without a commit
// Revision : 1.0 - initial release
// ============================================================================
module cursor_ctrl #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int IDLE_FRAMES = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_valid,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic        mouse_left,
  input  logic        set_req,
  input  logic [11:0] set_x,
  input  logic [11:0] set_y,
  output logic        set_ack,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        cursor_vis,
  output logic        frame_click
);

  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - 1);
  localparam logic [11:0] X_RST = 12'(H_ACTIVE / 2);
  localparam logic [11:0] Y_RST = 12'(V_ACTIVE / 2);

  if (H_ACTIVE < 1 || H_ACTIVE > 4096 || V_ACTIVE < 1 || V_ACTIVE > 4096 ||
      IDLE_FRAMES < 1 || IDLE_FRAMES > 65535) begin : g_param_range_err
    $error("cursor_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_COMMIT} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_MOUSE, SRC_SET} src_t;

  state_t      state;
  src_t        pend_src;
  logic [11:0] pend_x;
  logic [11:0] pend_y;
  logic        click_latch;
  logic        vblnk_q;
  logic        vblnk_qd;

  logic        set_cap;
  logic        mouse_cap;
  logic        capture;
  logic        click;
  logic        rise;

  function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] max);
    return (v > max) ? max : v;
  endfunction

  // A request still high in its own ack cycle is the tail of the one just
  // accepted; it only counts again once set_ack has dropped.
  assign set_cap   = set_req & ~set_ack;
  // A game-forced position is protected from mouse samples until it has been
  // committed; in the commit cycle itself the slot is free again.
  assign mouse_cap = mouse_valid & ~set_cap &
                     ((pend_src != SRC_SET) | (state == ST_COMMIT));
  // Dropped mouse samples still count as activity for the FSM.
  assign capture   = set_cap | mouse_valid;
  assign click     = mouse_valid & mouse_left;
  // vblnk is registered once before edge detection, which places the x/y
  // update exactly two clocks after vblnk is first sampled high.
  assign rise      = vblnk_q & ~vblnk_qd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pend_src    <= SRC_NONE;
      pend_x      <= '0;
      pend_y      <= '0;
      click_latch <= 1'b0;
      vblnk_q     <= 1'b0;
      vblnk_qd    <= 1'b0;
      set_ack     <= 1'b0;
      frame_click <= 1'b0;
      x           <= X_RST;
      y           <= Y_RST;
    end else begin
      vblnk_q     <= vblnk;
      vblnk_qd    <= vblnk_q;
      set_ack     <= set_cap;
      frame_click <= 1'b0;

      if (set_cap) begin
        pend_x   <= clamp(set_x, X_MAX);
        pend_y   <= clamp(set_y, Y_MAX);
        pend_src <= SRC_SET;
      end else if (mouse_cap) begin
        pend_x   <= clamp(mouse_x, X_MAX);
        pend_y   <= clamp(mouse_y, Y_MAX);
        pend_src <= SRC_MOUSE;
      end else if (state == ST_COMMIT) begin
        pend_src <= SRC_NONE;
      end

      if (state == ST_COMMIT) begin
        x           <= pend_x;
        y           <= pend_y;
        frame_click <= click_latch;
        // A click arriving in the commit cycle belongs to the next frame.
        click_latch <= click;
      end else if (click) begin
        click_latch <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          // A capture coinciding with vblank entry still makes this vblank.
          if (capture) state <= rise ? ST_COMMIT : ST_PENDING;
        end
        ST_PENDING: begin
          if (rise) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state <= capture ? ST_PENDING : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CURSOR_AUTOHIDE_EN
  localparam int CNT_W = ($clog2(IDLE_FRAMES + 1) > 8) ? $clog2(IDLE_FRAMES + 1) : 8;
  localparam logic [CNT_W-1:0] IDLE_CNT = CNT_W'(IDLE_FRAMES);

  logic [CNT_W-1:0] idle_cnt;
  logic             vis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      vis_q    <= 1'b1;
    end else if (state == ST_COMMIT) begin
      idle_cnt <= '0;
      vis_q    <= 1'b1;
    end else begin
      if (rise && idle_cnt != IDLE_CNT) idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == IDLE_CNT) vis_q <= 1'b0;
    end
  end

  assign cursor_vis = vis_q;
`else
  assign cursor_vis = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_ctrl
// Purpose  : Directed self-checking bench for cursor_ctrl (IDLE_FRAMES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        mouse_valid;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic        mouse_left;
  logic        set_req;
  logic [11:0] set_x;
  logic [11:0] set_y;
  logic        set_ack;
  logic [11:0] x;
  logic [11:0] y;
  logic        cursor_vis;
  logic        frame_click;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int click_cnt = 0;
  int ack_cnt   = 0;
  int click_base;

  cursor_ctrl #(
    .H_ACTIVE   (800),
    .V_ACTIVE   (600),
    .IDLE_FRAMES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .mouse_valid(mouse_valid),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .mouse_left (mouse_left),
    .set_req    (set_req),
    .set_x      (set_x),
    .set_y      (set_y),
    .set_ack    (set_ack),
    .x          (x),
    .y          (y),
    .cursor_vis (cursor_vis),
    .frame_click(frame_click)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_click === 1'b1) click_cnt++;
    if (set_ack === 1'b1) ack_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mouse(input int mx, input int my, input logic left);
    mouse_valid = 1'b1;
    mouse_x     = 12'(mx);
    mouse_y     = 12'(my);
    mouse_left  = left;
    tick();
    mouse_valid = 1'b0;
    mouse_left  = 1'b0;
  endtask

  task automatic frame();
    vblnk = 1'b1;
    repeat (8) tick();
    vblnk = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b0; mouse_valid = 1'b0; mouse_x = '0; mouse_y = '0;
    mouse_left = 1'b0; set_req = 1'b0; set_x = '0; set_y = '0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_x", x, 400);
    check_eq("rst_y", y, 300);
    check_eq("rst_vis", cursor_vis, 1);
    check_eq("rst_ack", set_ack, 0);
    check_eq("rst_click", frame_click, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Three idle frames: nothing moves, no click
    repeat (3) frame();
    check_eq("idle_x", x, 400);
    check_eq("idle_y", y, 300);
    check_eq("idle_vis", cursor_vis, 1);
    check_eq("idle_clicks", click_cnt, 0);

    // Mouse move held until vblank, then exactly two clocks of latency
    mouse(100, 50, 1'b0);
    repeat (5) tick();
    check_eq("hold_x", x, 400);
    vblnk = 1'b1;
    tick();
    check_eq("lat_e0_x", x, 400);
    tick();
    check_eq("lat_e1_x", x, 400);
    tick();
    check_eq("lat_e2_x", x, 100);
    check_eq("lat_e2_y", y, 50);
    repeat (5) tick();
    vblnk = 1'b0;
    repeat (8) tick();

    // Clamping
    mouse(4000, 700, 1'b0);
    frame();
    check_eq("clamp_x", x, 799);
    check_eq("clamp_y", y, 599);

    // Set and mouse in the same cycle: set wins and is protected
    set_req = 1'b1; set_x = 12'd10; set_y = 12'd20;
    mouse_valid = 1'b1; mouse_x = 12'd300; mouse_y = 12'd300;
    tick();
    check_eq("ack_hi", set_ack, 1);
    set_req = 1'b0;
    mouse_x = 12'd310; mouse_y = 12'd310;
    tick();
    mouse_valid = 1'b0;
    check_eq("ack_lo", set_ack, 0);
    frame();
    check_eq("set_x", x, 10);
    check_eq("set_y", y, 20);
    check_eq("ack_pulses", ack_cnt, 1);

    // Click: one pulse at commit, none in the next frame
    click_base = click_cnt;
    mouse(200, 200, 1'b1);
    repeat (4) tick();
    check_eq("click_early", click_cnt - click_base, 0);
    frame();
    check_eq("click_x", x, 200);
    check_eq("click_one", click_cnt - click_base, 1);
    mouse(210, 210, 1'b0);
    frame();
    check_eq("noclick_x", x, 210);
    check_eq("click_still_one", click_cnt - click_base, 1);

    // Capture during the commit cycle survives to the next vblank
    mouse(50, 60, 1'b0);
    vblnk = 1'b1;
    tick();
    tick();
    mouse_valid = 1'b1; mouse_x = 12'd70; mouse_y = 12'd80;
    tick();
    mouse_valid = 1'b0;
    check_eq("cc_first_x", x, 50);
    check_eq("cc_first_y", y, 60);
    repeat (6) tick();
    vblnk = 1'b0;
    repeat (8) tick();
    check_eq("cc_hold_x", x, 50);
    frame();
    check_eq("cc_second_x", x, 70);
    check_eq("cc_second_y", y, 80);

    // Mid-operation reset drops the pending position
    mouse(500, 500, 1'b1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    click_base = click_cnt;
    frame();
    check_eq("mrst_x", x, 400);
    check_eq("mrst_y", y, 300);
    check_eq("mrst_click", click_cnt - click_base, 0);

`ifdef CURSOR_AUTOHIDE_EN
    mouse(123, 45, 1'b0);
    frame();
    check_eq("ah_commit_x", x, 123);
    repeat (3) frame();
    check_eq("ah_vis_3", cursor_vis, 1);
    frame();
    check_eq("ah_vis_4", cursor_vis, 0);
    mouse(130, 50, 1'b0);
    repeat (4) tick();
    check_eq("ah_vis_premove", cursor_vis, 0);
    frame();
    check_eq("ah_vis_back", cursor_vis, 1);
    check_eq("ah_move_x", x, 130);
`else
    repeat (5) frame();
    check_eq("vis_tied", cursor_vis, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
